tuner_cic_decimator: RTL and testbench
======================================

# tuner_cic_decimator

- Dual-channel (I/Q) CIC decimator that consumes the full-rate `out_i`/`out_q` streams of the tuner.
- Reduces the sample rate by a runtime-selectable power of two.
- Produces gain-normalised, decimated baseband samples with a single-cycle valid strobe for the downstream FIR/packetiser.

## Interface
Parameters:
- `DSZ`, 16: input/output data word size
- `N`, 4: number of integrator/comb stages
- `RLOG2MAX`, 6: maximum log2 decimation ratio (R ≤ 64)
- `WSZ`, DSZ + N*RLOG2MAX = 40: internal accumulator width

Ports:
- `clk`, in, 1: clock
- `reset`, in, 1: synchronous, active-high reset
- `in_i`, in, DSZ signed: in-phase input, one sample per clk
- `in_q`, in, DSZ signed: quadrature input, one sample per clk
- `dec_log2`, in, 3: log2 of decimation ratio R; legal 1..RLOG2MAX; other values are treated as 1
- `out_i`, out, DSZ signed: decimated in-phase output
- `out_q`, out, DSZ signed: decimated quadrature output
- `out_valid`, out, 1: one-cycle strobe marking a new `out_i`/`out_q` pair

## Operation
- Integrators:
  - N cascaded registered integrators per channel, WSZ bits, sign-extended input.
  - Updated every clk.
  - Two's-complement wrap-around is intentional and must not be saturated.
- Decimation counter:
  - Counts 0..R-1, R = 2^dec_log2.
  - The cycle where count == R-1 is the decimation strobe: integrator-N output is captured into comb stage 1.
- Combs:
  - N registered comb stages per channel, WSZ bits, differential delay 1.
  - Each stage advances only when its stage-valid bit is set.
  - A valid shift register carries the strobe through the N combs and the output register.
- Output scaling:
  - Arithmetic right shift of the comb-N result by N*dec_log2 (floor, no rounding).
  - Lower DSZ bits taken.
  - DC gain is exactly 1, so no saturation is required.
- I and Q share the counter and valid pipeline, so they stay sample-aligned.
- `dec_log2` change:
  - Detected by comparing against a registered copy.
  - On the cycle after the change, the counter, all integrators, comb registers and the valid pipeline clear, exactly as on reset.
  - The new ratio applies from that point.
- Settling:
  - The first N decimated outputs after reset or a ratio change are transient.
  - They are still flagged with `out_valid`; filtering them is the consumer's job.

## Timing
- Reset values:
  - `out_i` = 0, `out_q` = 0, `out_valid` = 0.
  - Counter, integrators, combs and valid pipeline = 0.
- Reset mid-operation:
  - Takes effect on the next edge.
  - Any strobe already in the pipeline is discarded, so no `out_valid` is emitted for it.
- Input latency: a sample on `in_i` at edge k reaches the integrator-N output at edge k+N.
- Output latency: `out_valid` pulses exactly N+1 cycles after the decimation-strobe cycle.
- Output rate: `out_valid` period is exactly R cycles in steady state. Pulses never overlap because R ≥ 2 and the pipeline is not stalled.
- First strobe occurs R-1 cycles after reset deassertion.
- Simultaneous reset and ratio change: reset wins; the registered ratio loads the current `dec_log2`.

## Structure
- Shared package `tuner_pkg`: DSZ, CIC_N, RLOG2MAX, WSZ constants and a `cic_word_t` signed WSZ-bit typedef. The tuner uses the same DSZ.
- Sub-module `cic_chan`: one channel's integrators, combs and scaler.
  - Ports: clk, reset, clear, strobe, valid pipeline taps, din, dec_log2, dout.
  - Instantiated twice (I, Q).
- Top level owns the decimation counter, ratio-change detect and valid pipeline.

## Test plan
- Reset: hold `reset` 5 cycles with random inputs -> all outputs 0, `out_valid` low throughout, first `out_valid` at cycle R-1+N+1 after release.
- DC: `in_i`=1000, `in_q`=-1000, dec_log2=3 -> `out_valid` every 8 cycles; after 4 transient outputs, `out_i`=1000 and `out_q`=-1000 exactly.
- Full scale: `in_i`=-32768, `in_q`=32767, dec_log2=6 -> settled outputs -32768/32767; integrators wrap without error.
- Impulse: single `in_i`=16384 sample, dec_log2=1 -> output sequence matches the floor-scaled N=4, R=2 CIC impulse response from the golden model; `out_q` stays 0.
- Ratio change: switch dec_log2 3->5 mid-stream with DC 500 -> internal clear the next cycle, `out_valid` period becomes 32, settled output is 500.
- Reset mid-operation: assert `reset` one cycle after a strobe -> no `out_valid` for that strobe; restart timing is identical to the reset scenario.

Source files
------------

// File: rtl/tuner_pkg.sv
// tuner_pkg: shared tuner constants, CIC word type and ratio sanitiser
package tuner_pkg;
    localparam int DSZ = 16;
    localparam int CIC_N = 4;
    localparam int RLOG2MAX = 6;
    localparam int WSZ = DSZ + CIC_N * RLOG2MAX;
    typedef logic signed [WSZ-1:0] cic_word_t;
    // Out-of-range ratios fall back to decimate-by-2
    function automatic logic [2:0] eff_log2(input logic [2:0] d, input logic [2:0] max_log2);
        return (d == 3'd0 || d > max_log2) ? 3'd1 : d;
    endfunction
endpackage

// File: rtl/cic_chan.sv
// cic_chan: one channel of the CIC decimator (integrators, combs, gain scaler)
module cic_chan #(
    parameter int DSZ = 16,
    parameter int N = 4,
    parameter int WSZ = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  strobe,
    input  logic [N-1:0]          valid,
    input  logic signed [DSZ-1:0] din,
    input  logic [2:0]            dec_log2,
    output logic signed [DSZ-1:0] dout
);
    typedef logic signed [WSZ-1:0] word_t;
    word_t din_r;
    word_t integ [N];
    word_t comb [N];
    word_t dly [N];
    word_t comb_in [N];
    word_t scaled;
    logic [N-1:0] en;
    assign en = {valid[N-2:0], strobe};
    assign scaled = comb[N-1] >>> (N * dec_log2);
    for (genvar g = 0; g < N; g++) begin : g_in
        if (g == 0) begin : g_first
            assign comb_in[g] = integ[N-1];
        end else begin : g_rest
            assign comb_in[g] = comb[g-1];
        end
    end
    // Integrators wrap freely; the combs undo the wrap exactly
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            din_r <= '0;
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
                comb[k] <= '0;
                dly[k] <= '0;
            end
        end else begin
            din_r <= WSZ'(din);
            integ[0] <= integ[0] + din_r;
            for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
            for (int k = 0; k < N; k++) begin
                if (en[k]) begin
                    dly[k] <= comb_in[k];
                    comb[k] <= comb_in[k] - dly[k];
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) dout <= '0;
        else if (valid[N-1] && !clear) dout <= scaled[DSZ-1:0];
    end
endmodule

// File: rtl/tuner_cic_decimator.sv
// tuner_cic_decimator: I/Q CIC decimator with runtime power-of-two ratio
// and a shared decimation counter / valid pipeline for both channels.
module tuner_cic_decimator #(
    parameter int DSZ = tuner_pkg::DSZ,
    parameter int N = tuner_pkg::CIC_N,
    parameter int RLOG2MAX = tuner_pkg::RLOG2MAX,
    parameter int WSZ = DSZ + N * RLOG2MAX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [DSZ-1:0] in_i,
    input  logic signed [DSZ-1:0] in_q,
    input  logic [2:0]            dec_log2,
    output logic signed [DSZ-1:0] out_i,
    output logic signed [DSZ-1:0] out_q,
    output logic                  out_valid
);
    import tuner_pkg::*;
    logic [2:0] dec_reg;
    logic [2:0] ratio;
    logic [RLOG2MAX-1:0] cnt;
    logic [N:0] vpipe;
    logic clear;
    logic strobe;
    // A ratio change restarts the whole filter from zero state
    assign clear = dec_log2 != dec_reg;
    assign ratio = eff_log2(dec_reg, 3'(RLOG2MAX));
    assign strobe = cnt == RLOG2MAX'((1 << ratio) - 1);
    assign out_valid = vpipe[N];
    always_ff @(posedge clk) begin
        dec_reg <= dec_log2;
        if (reset || clear) begin
            cnt <= '0;
            vpipe <= '0;
        end else begin
            cnt <= strobe ? '0 : cnt + 1'b1;
            vpipe <= {vpipe[N-1:0], strobe};
        end
    end
    cic_chan #(.DSZ(DSZ), .N(N), .WSZ(WSZ)) u_chan_i (
        .clk(clk), .reset(reset), .clear(clear), .strobe(strobe),
        .valid(vpipe[N-1:0]), .din(in_i), .dec_log2(ratio), .dout(out_i)
    );
    cic_chan #(.DSZ(DSZ), .N(N), .WSZ(WSZ)) u_chan_q (
        .clk(clk), .reset(reset), .clear(clear), .strobe(strobe),
        .valid(vpipe[N-1:0]), .din(in_q), .dec_log2(ratio), .dout(out_q)
    );
endmodule

// File: tb/tb_tuner_cic_decimator.sv
// tb_tuner_cic_decimator: directed + random checks against a convolution
// model of the CIC (4-fold boxcar impulse response, floor-scaled).
module tb_tuner_cic_decimator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [15:0] in_i = '0;
    logic signed [15:0] in_q = '0;
    logic [2:0] dec_log2 = 3'd3;
    logic signed [15:0] out_i;
    logic signed [15:0] out_q;
    logic out_valid;

    always #5 clk = ~clk;

    tuner_cic_decimator dut (
        .clk(clk), .reset(reset), .in_i(in_i), .in_q(in_q),
        .dec_log2(dec_log2), .out_i(out_i), .out_q(out_q), .out_valid(out_valid)
    );

    int n_assert = 0;
    int n_fail = 0;
    int t = 0;
    int r_log = 1;
    int rr = 2;
    int dreg = 3;
    bit known = 0;
    int xi [4096];
    int xq [4096];
    longint h [256];
    int hlen = 1;
    logic signed [15:0] exp_i = '0;
    logic signed [15:0] exp_q = '0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0d", tag, obs, expv, t);
        end
    endtask

    // Impulse response of N=4 cascaded length-R boxcars
    task automatic restart(input int d);
        longint tmp [256];
        int nl;
        r_log = (d < 1 || d > 6) ? 1 : d;
        rr = 1 << r_log;
        hlen = 1;
        h[0] = 1;
        for (int s = 0; s < 4; s++) begin
            nl = hlen + rr - 1;
            for (int i = 0; i < nl; i++) tmp[i] = 0;
            for (int i = 0; i < hlen; i++)
                for (int j = 0; j < rr; j++) tmp[i+j] += h[i];
            for (int i = 0; i < nl; i++) h[i] = tmp[i];
            hlen = nl;
        end
        t = 0;
    endtask

    // Output at epoch cycle t comes from strobe cycle t-5, which sees inputs up to t-10
    function automatic logic signed [15:0] model_out(input bit q);
        longint acc = 0;
        longint y;
        int idx;
        for (int k = 0; k < hlen; k++) begin
            idx = t - 10 - k;
            if (idx >= 0) acc += h[k] * longint'(q ? xq[idx] : xi[idx]);
        end
        y = acc >>> (4 * r_log);
        return 16'(y);
    endfunction

    task automatic cyc(input bit r, input int d, input int vi, input int vq);
        bit ev;
        @(posedge clk);
        #1;
        reset = r;
        dec_log2 = 3'(d);
        in_i = 16'(vi);
        in_q = 16'(vq);
        @(negedge clk);
        if (known) begin
            ev = (t >= 5) && ((t - 5) % rr == rr - 1);
            if (ev) begin
                exp_i = model_out(1'b0);
                exp_q = model_out(1'b1);
            end
            chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
            chk("out_i", out_i, exp_i);
            chk("out_q", out_q, exp_q);
        end
        if (t < 4096) begin
            xi[t] = int'(in_i);
            xq[t] = int'(in_q);
        end
        if (r) begin
            restart(d);
            exp_i = '0;
            exp_q = '0;
            known = 1;
        end else if (d != dreg) restart(d);
        else t++;
        dreg = d;
    endtask

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    initial begin
        int d;
        int len;
        restart(3);
        // Reset with random inputs, then DC 1000/-1000 at R=8
        repeat (5) cyc(1, 3, rnd16(), rnd16());
        repeat (90) cyc(0, 3, 1000, -1000);
        chk("dc_settled_i", out_i, 1000);
        chk("dc_settled_q", out_q, -1000);
        // Full scale at R=64; integrators wrap
        repeat (64 * 8 + 12) cyc(0, 6, -32768, 32767);
        chk("fs_settled_i", out_i, -32768);
        chk("fs_settled_q", out_q, 32767);
        // Impulse at R=2
        repeat (12) cyc(0, 1, 0, 0);
        cyc(0, 1, 16384, 0);
        repeat (40) cyc(0, 1, 0, 0);
        // Ratio change 3 -> 5 on DC 500
        repeat (60) cyc(0, 3, 500, 500);
        repeat (32 * 7 + 10) cyc(0, 5, 500, 500);
        chk("rc_settled_i", out_i, 500);
        // Reset one cycle after a strobe
        repeat (20) cyc(0, 3, rnd16(), rnd16());
        while (t % 8 != 0) cyc(0, 3, rnd16(), rnd16());
        repeat (5) cyc(1, 3, rnd16(), rnd16());
        repeat (40) cyc(0, 3, rnd16(), rnd16());
        // Random ratios (including illegal 0/7), random data, occasional reset
        for (int s = 0; s < 12; s++) begin
            d = int'($urandom_range(0, 7));
            len = int'($urandom_range(20, 300));
            if ($urandom_range(0, 3) == 0) repeat (2) cyc(1, d, rnd16(), rnd16());
            repeat (len) cyc(0, d, rnd16(), rnd16());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
